// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C register-port responder: oversamples SCL/SDA, decodes START/STOP,
// answers one 7-bit device address, and serves a byte-wide register file.
`timescale 1ns/1ps
module sccb_slave_regfile #(
   parameter logic [6:0]  DEVICE_ADDR = 7'h21,
   parameter int unsigned REG_COUNT   = 256,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oen_o,
   output logic       wr_stb_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       busy_o,
   output logic       nack_o
);

   localparam int unsigned IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [7:0]  IDX_MASK = 8'(REG_COUNT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV_ADDR, S_ACK_ADDR, S_REG_IDX, S_ACK_IDX,
      S_WR_DATA, S_ACK_DATA, S_RD_DATA, S_RD_ACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   logic                   w_scl, w_sda;
   logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

   state_t     r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_index;
   logic       r_rw;
   logic       r_ack_en;
   logic       r_ack_phase;
   logic       r_mack;
   logic       r_sda_oen;
   logic       r_wr_stb;
   logic [7:0] r_wr_addr;
   logic [7:0] r_wr_data;
   logic       r_busy;
   logic       r_nack;
   logic [7:0] r_regs [REG_COUNT];

   logic [7:0] w_byte;
   logic [7:0] w_index_inc;
   logic       w_cur_in_range, w_nxt_in_range;
   logic [7:0] w_rd_cur, w_rd_nxt;

   // Synchronize the pad inputs and keep the previous synced level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

   assign w_byte         = {r_shift[6:0], w_sda};
   assign w_index_inc    = (r_index + 8'd1) & IDX_MASK;
   assign w_cur_in_range = 9'(r_index) < 9'(REG_COUNT);
   assign w_nxt_in_range = 9'(w_index_inc) < 9'(REG_COUNT);
   assign w_rd_cur       = w_cur_in_range ? r_regs[r_index[IDX_W-1:0]] : 8'hFF;
   assign w_rd_nxt       = w_nxt_in_range ? r_regs[w_index_inc[IDX_W-1:0]] : 8'hFF;

   // Protocol FSM: bit collection on SCL rise, SDA updates on SCL fall, register file writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_index     <= '0;
         r_rw        <= 1'b0;
         r_ack_en    <= 1'b0;
         r_ack_phase <= 1'b0;
         r_mack      <= 1'b1;
         r_sda_oen   <= 1'b1;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_nack      <= 1'b0;
         for (int i = 0; i < int'(REG_COUNT); i++) r_regs[i] <= '0;
      end else begin
         r_wr_stb <= 1'b0;
         r_nack   <= 1'b0;
         if (w_stop) begin
            r_state     <= S_IDLE;
            r_sda_oen   <= 1'b1;
            r_busy      <= 1'b0;
            r_ack_phase <= 1'b0;
         end else if (w_start) begin
            r_state     <= S_DEV_ADDR;
            r_bit_cnt   <= '0;
            r_sda_oen   <= 1'b1;
            r_ack_phase <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_IGNORE: begin
               end
               S_DEV_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        if (w_byte[7:1] == DEVICE_ADDR) begin
                           r_state  <= S_ACK_ADDR;
                           r_rw     <= w_byte[0];
                           r_busy   <= 1'b1;
                           r_ack_en <= 1'b1;
                        end else begin
                           r_nack  <= 1'b1;
                           r_state <= S_IGNORE;
                        end
                     end
                  end
               end
               S_REG_IDX: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_index  <= w_byte;
                        r_ack_en <= 1'b1;
                        r_state  <= S_ACK_IDX;
                     end
                  end
               end
               S_WR_DATA: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_state <= S_ACK_DATA;
                        if (w_cur_in_range) begin
                           r_regs[r_index[IDX_W-1:0]] <= w_byte;
                           r_wr_stb  <= 1'b1;
                           r_wr_addr <= r_index;
                           r_wr_data <= w_byte;
                           r_index   <= w_index_inc;
                           r_ack_en  <= 1'b1;
                        end else begin
                           r_nack   <= 1'b1;
                           r_ack_en <= 1'b0;
                        end
                     end
                  end
               end
               // ACK slot: first fall starts the ninth bit, second fall ends it
               S_ACK_ADDR, S_ACK_IDX, S_ACK_DATA: begin
                  if (w_scl_fall) begin
                     if (!r_ack_phase) begin
                        r_ack_phase <= 1'b1;
                        r_sda_oen   <= ~r_ack_en;
                     end else begin
                        r_ack_phase <= 1'b0;
                        r_sda_oen   <= 1'b1;
                        r_bit_cnt   <= '0;
                        if (r_state == S_ACK_ADDR) begin
                           if (r_rw) begin
                              r_shift   <= w_rd_cur;
                              r_sda_oen <= w_rd_cur[7];
                              r_state   <= S_RD_DATA;
                           end else begin
                              r_state <= S_REG_IDX;
                           end
                        end else begin
                           r_state <= S_WR_DATA;
                        end
                     end
                  end
               end
               S_RD_DATA: begin
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_oen <= 1'b1;
                        r_state   <= S_RD_ACK;
                     end else begin
                        r_sda_oen <= r_shift[6];
                        r_shift   <= {r_shift[6:0], 1'b0};
                     end
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     r_mack <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!r_mack) begin
                        r_index   <= w_index_inc;
                        r_shift   <= w_rd_nxt;
                        r_sda_oen <= w_rd_nxt[7];
                        r_bit_cnt <= '0;
                        r_state   <= S_RD_DATA;
                     end else begin
                        r_sda_oen <= 1'b1;
                        r_state   <= S_IGNORE;
                     end
                  end
               end
               default: begin
                  r_state   <= S_IDLE;
                  r_sda_oen <= 1'b1;
               end
            endcase
         end
      end
   end

   assign sda_oen_o = r_sda_oen;
   assign wr_stb_o  = r_wr_stb;
   assign wr_addr_o = r_wr_addr;
   assign wr_data_o = r_wr_data;
   assign busy_o    = r_busy;
   assign nack_o    = r_nack;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Bench for sccb_slave_regfile: open-drain SCCB master, table vectors, corner
// sequences, and random transactions against an array-based register model.
`timescale 1ns/1ps
module tb_sccb_slave_regfile;
   localparam int         Q   = 5;
   localparam logic [6:0] DEV = 7'h21;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   logic       sda_oen_o, wr_stb_o, busy_o, nack_o;
   logic [7:0] wr_addr_o, wr_data_o;

   int         n_vec  = 0;
   int         n_miss = 0;
   logic [15:0] act_q[$];
   int         nack_cnt = 0;
   logic [7:0] mregs [256];
   logic [7:0] midx;

   typedef struct {
      logic [7:0] dev;
      logic [7:0] idx;
      logic [7:0] d0, d1, d2;
      int         nd;
      logic       exp_ack;
      int         exp_stb;
      int         exp_nack;
   } vec_t;
   vec_t tab [6];

   assign sda_line = m_sda & sda_oen_o;

   sccb_slave_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (m_scl),
      .sda_i     (sda_line),
      .sda_oen_o (sda_oen_o),
      .wr_stb_o  (wr_stb_o),
      .wr_addr_o (wr_addr_o),
      .wr_data_o (wr_data_o),
      .busy_o    (busy_o),
      .nack_o    (nack_o)
   );

   always #5 clk = ~clk;

   // Record every write strobe and NACK pulse
   always @(negedge clk) begin
      if (wr_stb_o) act_q.push_back({wr_addr_o, wr_data_o});
      if (nack_o) nack_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
      midx = 8'h00;
   endtask

   task automatic m_start();
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b0; wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic m_stop();
      m_sda = 1'b0; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b1; wq();
   endtask

   task automatic m_send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         m_sda = b[i]; wq();
         m_scl = 1'b1; wq(); wq();
         m_scl = 1'b0; wq();
      end
   endtask

   task automatic m_write(input logic [7:0] b, output logic ack);
      m_send_bits(b);
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      ack = ~sda_line;
      wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic m_read(input logic mack, output logic [7:0] b);
      b = 8'h00;
      m_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wq();
         m_scl = 1'b1; wq();
         b[i] = sda_line;
         wq();
         m_scl = 1'b0; wq();
      end
      m_sda = mack; wq();
      m_scl = 1'b1; wq(); wq();
      m_scl = 1'b0; wq();
      m_sda = 1'b1;
   endtask

   task automatic do_write(input logic [7:0] dev, input logic [7:0] idx,
                           input logic [7:0] d [4], input int nd,
                           output logic addr_ack, output int n_stb, output int n_nk);
      logic        ack;
      logic        match;
      int          s0, k0;
      logic [15:0] exp_q[$];
      s0 = act_q.size();
      k0 = nack_cnt;
      match = (dev[7:1] == DEV) && !dev[0];
      m_start();
      m_write(dev, addr_ack);
      if (match) check("wr_busy", 32'(busy_o), 32'd1);
      m_write(idx, ack);
      check("wr_idx_ack", 32'(ack), 32'(match));
      if (match) midx = idx;
      for (int k = 0; k < nd; k++) begin
         m_write(d[k], ack);
         check("wr_data_ack", 32'(ack), 32'(match));
         if (match) begin
            exp_q.push_back({midx, d[k]});
            mregs[midx] = d[k];
            midx = midx + 8'd1;
         end
      end
      m_stop();
      wq();
      check("wr_busy_end", 32'(busy_o), 32'd0);
      n_stb = act_q.size() - s0;
      n_nk  = nack_cnt - k0;
      check("wr_stb_count", 32'(n_stb), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < n_stb; k++)
         check("wr_stb_addr_data", 32'(act_q[s0+k]), 32'(exp_q[k]));
   endtask

   task automatic do_read(input logic set_idx, input logic [7:0] idx, input int n,
                          output logic [7:0] got [4]);
      logic       ack;
      logic       mack;
      logic [7:0] b;
      int         s0;
      s0 = act_q.size();
      for (int k = 0; k < 4; k++) got[k] = 8'h00;
      m_start();
      if (set_idx) begin
         m_write(8'h42, ack);
         check("rd_waddr_ack", 32'(ack), 32'd1);
         m_write(idx, ack);
         check("rd_idx_ack", 32'(ack), 32'd1);
         midx = idx;
         m_start();
      end
      m_write(8'h43, ack);
      check("rd_addr_ack", 32'(ack), 32'd1);
      check("rd_busy", 32'(busy_o), 32'd1);
      for (int k = 0; k < n; k++) begin
         mack = (k == n - 1);
         m_read(mack, b);
         got[k] = b;
         check($sformatf("rd_byte_idx%02h", midx), 32'(b), 32'(mregs[midx]));
         if (!mack) midx = midx + 8'd1;
      end
      check("rd_release_after_nack", 32'(sda_oen_o), 32'd1);
      m_stop();
      wq();
      check("rd_busy_end", 32'(busy_o), 32'd0);
      check("rd_no_stb", 32'(act_q.size() - s0), 32'd0);
   endtask

   initial begin : main
      logic [7:0] d [4];
      logic [7:0] got [4];
      logic       a_ack;
      int         n_stb, n_nk, s0, r, nd;
      logic [7:0] idx, dev, last_idx;
      logic [7:0] pat;

      tab[0] = '{8'h42, 8'h12, 8'h80, 8'h00, 8'h00, 1, 1'b1, 1, 0};
      tab[1] = '{8'h42, 8'h3A, 8'h04, 8'h05, 8'h00, 2, 1'b1, 2, 0};
      tab[2] = '{8'h44, 8'h10, 8'h55, 8'h00, 8'h00, 1, 1'b0, 0, 1};
      tab[3] = '{8'h42, 8'hFF, 8'hAA, 8'hBB, 8'h00, 2, 1'b1, 2, 0};
      tab[4] = '{8'h42, 8'h20, 8'h00, 8'h00, 8'h00, 0, 1'b1, 0, 0};
      tab[5] = '{8'h40, 8'h30, 8'h11, 8'h22, 8'h33, 3, 1'b0, 0, 1};

      model_reset();
      repeat (3) @(negedge clk);
      check("rst_sda_oen", 32'(sda_oen_o), 32'd1);
      check("rst_wr_stb",  32'(wr_stb_o),  32'd0);
      check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
      check("rst_wr_data", 32'(wr_data_o), 32'd0);
      check("rst_busy",    32'(busy_o),    32'd0);
      check("rst_nack",    32'(nack_o),    32'd0);
      rst = 1'b0;
      wq();

      for (int v = 0; v < 6; v++) begin
         d[0] = tab[v].d0; d[1] = tab[v].d1; d[2] = tab[v].d2; d[3] = 8'h00;
         do_write(tab[v].dev, tab[v].idx, d, tab[v].nd, a_ack, n_stb, n_nk);
         check($sformatf("vec%0d_addr_ack", v), 32'(a_ack), 32'(tab[v].exp_ack));
         check($sformatf("vec%0d_stb_cnt", v),  32'(n_stb), 32'(tab[v].exp_stb));
         check($sformatf("vec%0d_nack_cnt", v), 32'(n_nk),  32'(tab[v].exp_nack));
      end

      // Repeated-START read back of the burst and of the wrapped burst
      do_read(1'b1, 8'h3A, 2, got);
      check("rd3A_b0", 32'(got[0]), 32'h04);
      check("rd3A_b1", 32'(got[1]), 32'h05);
      do_read(1'b1, 8'hFF, 2, got);
      check("rdFF_b0", 32'(got[0]), 32'hAA);
      check("rd00_wrap", 32'(got[1]), 32'hBB);
      do_read(1'b1, 8'h12, 1, got);
      check("rd12", 32'(got[0]), 32'h80);

      // Reset during data bit 4 of a write
      s0 = act_q.size();
      m_start();
      m_write(8'h42, a_ack);
      m_write(8'h20, a_ack);
      pat = 8'h99;
      for (int i = 7; i >= 5; i--) begin
         m_sda = pat[i]; wq();
         m_scl = 1'b1; wq(); wq();
         m_scl = 1'b0; wq();
      end
      m_sda = pat[4]; wq();
      m_scl = 1'b1; wq();
      rst = 1'b1;
      #1;
      check("rstmid_sda_oen", 32'(sda_oen_o), 32'd1);
      check("rstmid_busy", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_scl = 1'b1; m_sda = 1'b1;
      wq(); wq();
      model_reset();
      check("rstmid_no_stb", 32'(act_q.size() - s0), 32'd0);
      do_read(1'b1, 8'h3A, 1, got);
      check("rstmid_reg_cleared", 32'(got[0]), 32'h00);
      d[0] = 8'h77;
      do_write(8'h42, 8'h20, d, 1, a_ack, n_stb, n_nk);
      check("rstmid_next_ack", 32'(a_ack), 32'd1);
      check("rstmid_next_stb", 32'(n_stb), 32'd1);

      // Reset while the responder is driving the address ACK
      m_start();
      m_send_bits(8'h42);
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      check("ack_driven", 32'(sda_oen_o), 32'd0);
      rst = 1'b1;
      #1;
      check("rstack_release", 32'(sda_oen_o), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_scl = 1'b1; m_sda = 1'b1;
      wq(); wq();
      model_reset();

      // Random transactions against the register model
      last_idx = 8'h00;
      for (int t = 0; t < 30; t++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            idx = 8'($urandom);
            nd  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            do_write(8'h42, idx, d, nd, a_ack, n_stb, n_nk);
            check("rnd_wr_addr_ack", 32'(a_ack), 32'd1);
            check("rnd_wr_nack", 32'(n_nk), 32'd0);
            last_idx = idx;
         end else if (r <= 7) begin
            do_read(1'b1, last_idx, $urandom_range(1, 3), got);
         end else if (r == 8) begin
            dev = {7'($urandom_range(0, 127)), 1'b0};
            if (dev[7:1] == DEV) dev = 8'h44;
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            do_write(dev, 8'($urandom), d, 2, a_ack, n_stb, n_nk);
            check("rnd_bad_addr_ack", 32'(a_ack), 32'd0);
            check("rnd_bad_nack", 32'(n_nk), 32'd1);
         end else begin
            do_read(1'b0, 8'h00, $urandom_range(1, 3), got);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
